// File: rtl/lsu_req_ctrl.sv
// lsu_req_ctrl: issues one LD/ST/LDU access at a time on the SRAM-like data bus and aligns/extends load data
module lsu_req_ctrl #(
    parameter int ADDR_W = 32,
    parameter int RST_PC = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_valid,
    input  logic              ex_ld,
    input  logic              ex_ldu,
    input  logic              ex_st,
    input  logic [1:0]        ex_size,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic              flush,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              ex_stall,
    output logic              ale,
    output logic              ld_valid,
    output logic [31:0]       ld_result
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, CANCEL} state_t;

    if (RST_PC != 0) begin : g_rst_pc_check
        $error("RST_PC is reserved and must be 0");
    end

    state_t            state_q, state_d;
    logic              data_req_q, data_req_d;
    logic              data_wr_q, data_wr_d;
    logic [1:0]        data_size_q, data_size_d;
    logic [3:0]        data_wstrb_q, data_wstrb_d;
    logic [ADDR_W-1:0] data_addr_q, data_addr_d;
    logic [31:0]       data_wdata_q, data_wdata_d;
    logic              sign_q, sign_d;
    logic              ale_q, ale_d;
    logic              ld_valid_q, ld_valid_d;
    logic [31:0]       ld_result_q, ld_result_d;
    logic              mem_op, is_half, is_word, misalign, ale_cond, issuing;
    logic [3:0]        st_strb;
    logic [31:0]       st_wdata, rd_shift, ld_ext;

    always_comb begin
        mem_op   = ex_valid & (ex_ld | ex_ldu | ex_st);
        is_half  = ex_size == 2'd1;
        is_word  = ex_size[1];
        misalign = (is_half & ex_addr[0]) | (is_word & |ex_addr[1:0]);
        ale_cond = (state_q == IDLE) & mem_op & !flush & misalign;
        issuing  = (state_q == IDLE) & mem_op & !flush & !misalign;
        ex_stall = mem_op & !ale_cond & ((state_q != IDLE) | issuing);
        st_strb  = is_word ? 4'hf : is_half ? (ex_addr[1] ? 4'hc : 4'h3) : 4'b0001 << ex_addr[1:0];
        st_wdata = is_word ? ex_wdata : is_half ? {2{ex_wdata[15:0]}} : {4{ex_wdata[7:0]}};
        rd_shift = data_size_q[1] ? data_rdata :
                   data_size_q[0] ? data_rdata >> {data_addr_q[1], 4'b0000} :
                                    data_rdata >> {data_addr_q[1:0], 3'b000};
        ld_ext   = data_size_q[1] ? rd_shift :
                   data_size_q[0] ? {{16{sign_q & rd_shift[15]}}, rd_shift[15:0]} :
                                    {{24{sign_q & rd_shift[7]}}, rd_shift[7:0]};
    end

    always_comb begin
        state_d      = state_q;
        data_req_d   = data_req_q;
        data_wr_d    = data_wr_q;
        data_size_d  = data_size_q;
        data_wstrb_d = data_wstrb_q;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        sign_d       = sign_q;
        ale_d        = ale_cond;
        ld_valid_d   = 1'b0;
        ld_result_d  = ld_result_q;
        case (state_q)
            IDLE: if (issuing) begin
                state_d      = REQ;
                data_req_d   = 1'b1;
                data_wr_d    = ex_st;
                data_size_d  = ex_size;
                data_wstrb_d = ex_st ? st_strb : 4'h0;
                data_addr_d  = ex_addr;
                data_wdata_d = st_wdata;
                sign_d       = ex_ld;
            end
            REQ: if (data_addr_ok) begin
                data_req_d = 1'b0;
                state_d    = flush ? CANCEL : WAIT;
            end else if (flush) begin
                data_req_d = 1'b0;
                state_d    = IDLE;
            end
            WAIT: if (data_data_ok) begin
                state_d = IDLE;
                if (!data_wr_q && !flush) begin
                    ld_valid_d  = 1'b1;
                    ld_result_d = ld_ext;
                end
            end else if (flush) begin
                state_d = CANCEL;
            end
            CANCEL: state_d = data_data_ok ? IDLE : CANCEL;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            data_req_q   <= 1'b0;
            data_wr_q    <= 1'b0;
            data_size_q  <= 2'd0;
            data_wstrb_q <= 4'h0;
            data_addr_q  <= '0;
            data_wdata_q <= 32'h0;
            sign_q       <= 1'b0;
            ale_q        <= 1'b0;
            ld_valid_q   <= 1'b0;
            ld_result_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            data_req_q   <= data_req_d;
            data_wr_q    <= data_wr_d;
            data_size_q  <= data_size_d;
            data_wstrb_q <= data_wstrb_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            sign_q       <= sign_d;
            ale_q        <= ale_d;
            ld_valid_q   <= ld_valid_d;
            ld_result_q  <= ld_result_d;
        end
    end

    assign data_req   = data_req_q;
    assign data_wr    = data_wr_q;
    assign data_size  = data_size_q;
    assign data_wstrb = data_wstrb_q;
    assign data_addr  = data_addr_q;
    assign data_wdata = data_wdata_q;
    assign ale        = ale_q;
    assign ld_valid   = ld_valid_q;
    assign ld_result  = ld_result_q;
endmodule

// File: tb/tb_lsu_req_ctrl.sv
// tb_lsu_req_ctrl: randomized transaction-level check of lsu_req_ctrl against a byte-lane reference model
module tb_lsu_req_ctrl;
    logic        clk = 1'b0;
    logic        resetn, ex_valid, ex_ld, ex_ldu, ex_st, flush;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        ex_stall, ale, ld_valid;
    logic [31:0] ld_result;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_result;

    lsu_req_ctrl #(.ADDR_W(32), .RST_PC(0)) dut (
        .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_ld(ex_ld), .ex_ldu(ex_ldu),
        .ex_st(ex_st), .ex_size(ex_size), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .ex_stall(ex_stall), .ale(ale),
        .ld_valid(ld_valid), .ld_result(ld_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req"}, 32'(data_req), 0);
        chk({tag, "_ale"}, 32'(ale), 0);
        chk({tag, "_ldv"}, 32'(ld_valid), 0);
        chk({tag, "_res"}, ld_result, 0);
        chk({tag, "_wr"}, 32'(data_wr), 0);
        chk({tag, "_size"}, 32'(data_size), 0);
        chk({tag, "_strb"}, 32'(data_wstrb), 0);
        chk({tag, "_addr"}, data_addr, 0);
        chk({tag, "_wdata"}, data_wdata, 0);
    endtask

    // kind: 0=ld 1=ldu 2=st; fmode: 0 none,1 flush in REQ,2 flush+addr_ok,3 flush in WAIT,4 flush+data_ok,5 reset in WAIT
    task automatic do_op(input int kind, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int ack_dly, input int resp_dly, input int fmode);
        int          nb;
        logic [1:0]  a;
        logic [3:0]  es;
        logic [31:0] ew, er, mask;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a = addr[1:0];
        for (int i = 0; i < 4; i++) begin
            es[i] = (kind == 2) && (i >= int'(a)) && (i < int'(a) + nb);
            ew[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        mask = 32'((64'd1 << (8 * nb)) - 64'd1);
        er = (rd >> (8 * int'(a))) & mask;
        if (kind == 0 && nb < 4 && er[8*nb-1]) er = er | ~mask;
        ex_valid = 1'b1; ex_ld = kind == 0; ex_ldu = kind == 1; ex_st = kind == 2;
        ex_size = sz; ex_addr = addr; ex_wdata = wd;
        #1;
        if (int'(a) % nb != 0) begin
            chk("ale_stall", 32'(ex_stall), 0);
            tick;
            chk("ale_pulse", 32'(ale), 1);
            chk("ale_noreq", 32'(data_req), 0);
            ex_valid = 1'b0;
            tick;
            chk("ale_drop", 32'(ale), 0);
            chk("ale_noreq2", 32'(data_req), 0);
            return;
        end
        chk("issue_stall", 32'(ex_stall), 1);
        tick;
        chk("req_on", 32'(data_req), 1);
        chk("req_wr", 32'(data_wr), 32'(kind == 2));
        chk("req_size", 32'(data_size), 32'(sz));
        chk("req_strb", 32'(data_wstrb), 32'(es));
        chk("req_addr", data_addr, addr);
        if (kind == 2) chk("req_wdata", data_wdata, ew);
        ex_addr = $urandom; ex_wdata = $urandom; ex_size = 2'($urandom);
        for (int k = 0; k < ack_dly; k++) begin
            if (fmode == 1 && k == ack_dly - 1) begin
                flush = 1'b1;
                #1 chk("wd_stall", 32'(ex_stall), 1);
                tick;
                flush = 1'b0; ex_valid = 1'b0;
                chk("wd_req", 32'(data_req), 0);
                #1 chk("wd_unstall", 32'(ex_stall), 0);
                tick;
                chk("wd_idle", 32'(data_req), 0);
                chk("wd_noldv", 32'(ld_valid), 0);
                return;
            end
            #1 chk("hold_stall", 32'(ex_stall), 1);
            tick;
            chk("hold_req", 32'(data_req), 1);
            chk("hold_addr", data_addr, addr);
            chk("hold_strb", 32'(data_wstrb), 32'(es));
            if (kind == 2) chk("hold_wdata", data_wdata, ew);
        end
        data_addr_ok = 1'b1; flush = fmode == 2;
        #1 chk("ack_stall", 32'(ex_stall), 1);
        tick;
        data_addr_ok = 1'b0; flush = 1'b0;
        chk("ack_req", 32'(data_req), 0);
        for (int k = 0; k < resp_dly; k++) begin
            if (fmode == 5) begin
                resetn = 1'b0; ex_valid = 1'b0;
                tick;
                chk_idle_outputs("rst_wait");
                #1 chk("rst_stall", 32'(ex_stall), 0);
                resetn = 1'b1; last_result = 32'h0;
                tick;
                chk("rst_noreq", 32'(data_req), 0);
                return;
            end
            flush = fmode == 3 && k == 0;
            #1 chk("wait_stall", 32'(ex_stall), 1);
            chk("wait_noldv", 32'(ld_valid), 0);
            tick;
            flush = 1'b0;
        end
        data_data_ok = 1'b1; data_rdata = rd; flush = fmode == 4;
        #1 chk("resp_stall", 32'(ex_stall), 1);
        tick;
        data_data_ok = 1'b0; flush = 1'b0; data_rdata = $urandom; ex_valid = 1'b0;
        chk("ld_valid", 32'(ld_valid), 32'(kind != 2 && fmode == 0));
        if (kind != 2 && fmode == 0) last_result = er;
        chk("ld_result", ld_result, last_result);
        chk("done_req", 32'(data_req), 0);
        #1 chk("done_stall", 32'(ex_stall), 0);
        tick;
        chk("ldv_pulse", 32'(ld_valid), 0);
    endtask

    initial begin
        resetn = 1'b0; ex_valid = 1'b0; ex_ld = 1'b0; ex_ldu = 1'b0; ex_st = 1'b0; flush = 1'b0;
        ex_size = 2'd0; ex_addr = 32'h0; ex_wdata = 32'h0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0; last_result = 32'h0;
        tick; tick;
        chk_idle_outputs("reset");
        resetn = 1'b1;
        tick;
        do_op(0, 2'd2, 32'h1000, 32'h0, 32'hDEADBEEF, 1, 2, 0);
        do_op(0, 2'd0, 32'h1003, 32'h0, 32'h80123456, 0, 1, 0);
        do_op(1, 2'd0, 32'h1003, 32'h0, 32'h80123456, 0, 1, 0);
        do_op(2, 2'd1, 32'h1002, 32'h1234, 32'h0, 0, 1, 0);
        do_op(0, 2'd2, 32'h1002, 32'h0, 32'h0, 0, 0, 0);
        do_op(2, 2'd2, 32'h2000, 32'hCAFEF00D, 32'h0, 5, 1, 0);
        do_op(2, 2'd2, 32'h2000, 32'hCAFEF00D, 32'h0, 3, 1, 1);
        do_op(0, 2'd2, 32'h3000, 32'h0, 32'h11223344, 0, 2, 3);
        do_op(0, 2'd2, 32'h3004, 32'h0, 32'h55667788, 1, 1, 0);
        do_op(1, 2'd1, 32'h3006, 32'h0, 32'h9ABC0000, 0, 1, 2);
        do_op(0, 2'd1, 32'h3006, 32'h0, 32'h9ABC0000, 0, 0, 4);
        do_op(0, 2'd1, 32'h3006, 32'h0, 32'h9ABC0000, 0, 0, 0);
        do_op(0, 2'd3, 32'h4000, 32'h0, 32'h0BADCAFE, 0, 0, 0);
        do_op(0, 2'd2, 32'h5000, 32'h0, 32'h12345678, 0, 2, 5);
        do_op(1, 2'd2, 32'h5004, 32'h0, 32'hA5A5A5A5, 0, 0, 0);
        for (int n = 0; n < 80; n++) begin
            int kind, ack, resp, fm;
            kind = $urandom_range(0, 2);
            ack = $urandom_range(0, 3);
            resp = $urandom_range(0, 3);
            fm = ($urandom_range(0, 9) < 5) ? 0 : $urandom_range(1, 4);
            if (fm == 1 && ack == 0) fm = 0;
            if (fm == 3 && resp == 0) fm = 0;
            do_op(kind, 2'($urandom), $urandom, $urandom, $urandom, ack, resp, fm);
            if ($urandom_range(0, 3) == 0) tick;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
